// File: rtl/reg_dump_reader.sv
// Register-file dump engine: walks addresses 0..NUM_REGS-1, streams each byte
// over a valid/ready interface and finishes with an XOR checksum byte.
module reg_dump_reader #(
  parameter int unsigned NUM_REGS = 8,
  parameter int unsigned ADDR_W   = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_data,
  output logic              out_last
);

  typedef enum logic [1:0] {IDLE, READ, SEND, CSUM} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);

  state_t            state_q, state_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              out_valid_q, out_valid_d;
  logic              out_last_q, out_last_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [7:0]        out_data_q, out_data_d;
  logic [7:0]        csum_q, csum_d;

  always_comb begin
    state_d     = state_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    rd_addr_d   = rd_addr_q;
    out_data_d  = out_data_q;
    csum_d      = csum_q;

    case (state_q)
      IDLE: begin
        busy_d      = 1'b0;
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
        rd_addr_d   = '0;
        csum_d      = '0;
        if (start) begin
          state_d = READ;
          busy_d  = 1'b1;
        end
      end
      READ: begin
        out_data_d  = rd_data;
        csum_d      = csum_q ^ rd_data;
        out_valid_d = 1'b1;
        state_d     = SEND;
      end
      SEND: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (rd_addr_q == LAST_ADDR) begin
            out_data_d = csum_q;
            state_d    = CSUM;
          end else begin
            rd_addr_d = rd_addr_q + ADDR_W'(1);
            state_d   = READ;
          end
        end
      end
      CSUM: begin
        // First CSUM cycle is a load slot, keeping the two-cycle byte cadence
        // for the checksum as well; valid rises on the following edge.
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
          out_last_d  = 1'b1;
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          done_d      = 1'b1;
          busy_d      = 1'b0;
          rd_addr_d   = '0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      rd_addr_q   <= '0;
      out_data_q  <= '0;
      csum_q      <= '0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      rd_addr_q   <= rd_addr_d;
      out_data_q  <= out_data_d;
      csum_q      <= csum_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign rd_addr   = rd_addr_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_reg_dump_reader.sv
// Directed bench for reg_dump_reader: stream content, cycle timing,
// backpressure, start handling, mid-dump reset and register sampling.
module tb_reg_dump_reader;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       busy;
  logic       done;
  logic [2:0] rd_addr;
  logic [7:0] rd_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_last;

  logic [7:0] regs [8];
  assign rd_data = regs[rd_addr];

  int vec  = 0;
  int errs = 0;

  // per-cycle trace, index n = negedge after edge n (edge 0 samples start)
  logic       tr_valid [64];
  logic       tr_last  [64];
  logic       tr_busy  [64];
  logic [7:0] tr_data  [64];
  logic [2:0] tr_addr  [64];
  logic [7:0] gd [64];
  logic       gl [64];
  int         nb;
  int         dn;
  int         dcyc [4];

  reg_dump_reader #(.NUM_REGS(8), .ADDR_W(3)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .rd_addr(rd_addr), .rd_data(rd_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_last(out_last)
  );

  always #5 clk = ~clk;

  task automatic kick();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic collect(input int limit, input int stall_byte, input int stall_len,
                         input int pulse_n, input int hold_from, input int hold_to,
                         input int mod_n);
    int stall_left;
    stall_left = stall_len;
    nb = 0;
    dn = 0;
    for (int i = 0; i < 4; i++) dcyc[i] = -1;
    for (int i = 0; i < 64; i++) begin
      gd[i] = 8'h00;
      gl[i] = 1'b0;
    end
    for (int n = 0; n < limit; n++) begin
      tr_valid[n] = out_valid;
      tr_last[n]  = out_last;
      tr_busy[n]  = busy;
      tr_data[n]  = out_data;
      tr_addr[n]  = rd_addr;
      if (done) begin
        if (dn < 4) dcyc[dn] = n;
        dn++;
      end
      if (n == mod_n) regs[0] = 8'h22;
      start = (n == pulse_n) || (n >= hold_from && n < hold_to);
      if (out_valid && nb == stall_byte && stall_left > 0) begin
        out_ready = 1'b0;
        stall_left--;
      end else begin
        out_ready = 1'b1;
      end
      if (out_valid && out_ready && nb < 64) begin
        gd[nb] = out_data;
        gl[nb] = out_last;
        nb++;
      end
      @(negedge clk);
    end
    start     = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    vec++; if (busy !== 1'b0)      begin errs++; $display("FAIL rst_busy got %b exp 0", busy); end
    vec++; if (done !== 1'b0)      begin errs++; $display("FAIL rst_done got %b exp 0", done); end
    vec++; if (rd_addr !== 3'd0)   begin errs++; $display("FAIL rst_addr got %0d exp 0", rd_addr); end
    vec++; if (out_valid !== 1'b0) begin errs++; $display("FAIL rst_valid got %b exp 0", out_valid); end
    vec++; if (out_data !== 8'h00) begin errs++; $display("FAIL rst_data got %h exp 00", out_data); end
    vec++; if (out_last !== 1'b0)  begin errs++; $display("FAIL rst_last got %b exp 0", out_last); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_incrementing();
    for (int i = 0; i < 8; i++) regs[i] = 8'(i + 1);
    kick();
    collect(26, -1, 0, -1, -1, -1, -1);
    vec++; if (nb !== 9) begin errs++; $display("FAIL inc_count got %0d exp 9", nb); end
    vec++; if (tr_busy[0] !== 1'b1) begin errs++; $display("FAIL inc_busy_rise got %b exp 1", tr_busy[0]); end
    for (int k = 0; k < 8; k++) begin
      vec++;
      if (gd[k] !== 8'(k + 1) || gl[k] !== 1'b0) begin
        errs++; $display("FAIL inc_byte%0d got %h/%b exp %h/0", k, gd[k], gl[k], 8'(k + 1));
      end
      vec++;
      if (tr_valid[2*k+1] !== 1'b1 || tr_data[2*k+1] !== 8'(k + 1)) begin
        errs++; $display("FAIL inc_time%0d got v=%b d=%h exp v=1 d=%h", k, tr_valid[2*k+1], tr_data[2*k+1], 8'(k + 1));
      end
    end
    vec++; if (gd[8] !== 8'h08 || gl[8] !== 1'b1) begin errs++; $display("FAIL inc_csum got %h/%b exp 08/1", gd[8], gl[8]); end
    vec++; if (tr_valid[16] !== 1'b0) begin errs++; $display("FAIL inc_csum_gap got %b exp 0", tr_valid[16]); end
    vec++; if (tr_valid[17] !== 1'b1 || tr_last[17] !== 1'b1) begin errs++; $display("FAIL inc_csum_time got %b/%b exp 1/1", tr_valid[17], tr_last[17]); end
    vec++; if (dn !== 1) begin errs++; $display("FAIL inc_done_count got %0d exp 1", dn); end
    vec++; if (dcyc[0] !== 18) begin errs++; $display("FAIL inc_done_time got %0d exp 18", dcyc[0]); end
    vec++; if (tr_busy[18] !== 1'b0) begin errs++; $display("FAIL inc_busy_at_done got %b exp 0", tr_busy[18]); end
  endtask

  task automatic test_all_a5();
    for (int i = 0; i < 8; i++) regs[i] = 8'hA5;
    kick();
    collect(26, -1, 0, -1, -1, -1, -1);
    vec++; if (nb !== 9) begin errs++; $display("FAIL a5_count got %0d exp 9", nb); end
    for (int k = 0; k < 8; k++) begin
      vec++; if (gd[k] !== 8'hA5) begin errs++; $display("FAIL a5_byte%0d got %h exp a5", k, gd[k]); end
    end
    vec++; if (gd[8] !== 8'h00 || gl[8] !== 1'b1) begin errs++; $display("FAIL a5_csum got %h/%b exp 00/1", gd[8], gl[8]); end
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 8; i++) regs[i] = 8'(i + 1);
    kick();
    collect(30, 2, 3, -1, -1, -1, -1);
    for (int n = 5; n <= 8; n++) begin
      vec++;
      if (tr_valid[n] !== 1'b1 || tr_data[n] !== 8'h03 || tr_addr[n] !== 3'd2 || tr_last[n] !== 1'b0) begin
        errs++; $display("FAIL bp_hold%0d got v=%b d=%h a=%0d l=%b exp v=1 d=03 a=2 l=0", n, tr_valid[n], tr_data[n], tr_addr[n], tr_last[n]);
      end
    end
    vec++; if (nb !== 9) begin errs++; $display("FAIL bp_count got %0d exp 9", nb); end
    vec++; if (gd[2] !== 8'h03 || gd[8] !== 8'h08) begin errs++; $display("FAIL bp_bytes got %h,%h exp 03,08", gd[2], gd[8]); end
    vec++; if (dcyc[0] !== 21) begin errs++; $display("FAIL bp_done_time got %0d exp 21", dcyc[0]); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) regs[i] = 8'(i + 1);
    kick();
    // mid-dump pulse at n=5, start held over the first done (n=15..18)
    collect(45, -1, 0, 5, 15, 19, -1);
    vec++; if (nb !== 18) begin errs++; $display("FAIL b2b_count got %0d exp 18", nb); end
    vec++; if (dn !== 2) begin errs++; $display("FAIL b2b_done_count got %0d exp 2", dn); end
    vec++; if (dcyc[0] !== 18 || dcyc[1] !== 37) begin errs++; $display("FAIL b2b_done_time got %0d,%0d exp 18,37", dcyc[0], dcyc[1]); end
    vec++; if (tr_busy[19] !== 1'b1) begin errs++; $display("FAIL b2b_restart got %b exp 1", tr_busy[19]); end
    vec++; if (tr_valid[20] !== 1'b1 || tr_data[20] !== 8'h01) begin errs++; $display("FAIL b2b_first2 got %b/%h exp 1/01", tr_valid[20], tr_data[20]); end
    vec++; if (gd[9] !== 8'h01 || gd[16] !== 8'h08 || gl[16] !== 1'b0) begin errs++; $display("FAIL b2b_bytes2 got %h,%h/%b exp 01,08/0", gd[9], gd[16], gl[16]); end
    vec++; if (gd[17] !== 8'h08 || gl[17] !== 1'b1) begin errs++; $display("FAIL b2b_csum2 got %h/%b exp 08/1", gd[17], gl[17]); end
  endtask

  task automatic test_reset_mid();
    int late_done;
    for (int i = 0; i < 8; i++) regs[i] = 8'(i + 1);
    kick();
    out_ready = 1'b1;
    repeat (9) @(negedge clk);
    vec++; if (out_valid !== 1'b1 || out_data !== 8'h05 || rd_addr !== 3'd4) begin errs++; $display("FAIL rm_pre got v=%b d=%h a=%0d exp 1/05/4", out_valid, out_data, rd_addr); end
    reset = 1'b1;
    @(negedge clk);
    vec++; if (busy !== 1'b0 || out_valid !== 1'b0) begin errs++; $display("FAIL rm_idle got busy=%b v=%b exp 0/0", busy, out_valid); end
    vec++; if (rd_addr !== 3'd0 || done !== 1'b0) begin errs++; $display("FAIL rm_addr_done got a=%0d d=%b exp 0/0", rd_addr, done); end
    reset = 1'b0;
    late_done = 0;
    for (int n = 0; n < 4; n++) begin
      if (done || busy) late_done++;
      @(negedge clk);
    end
    vec++; if (late_done !== 0) begin errs++; $display("FAIL rm_quiet got %0d exp 0", late_done); end
    kick();
    collect(26, -1, 0, -1, -1, -1, -1);
    vec++; if (nb !== 9 || gd[0] !== 8'h01 || gd[4] !== 8'h05) begin errs++; $display("FAIL rm_stream got n=%0d %h,%h exp 9 01,05", nb, gd[0], gd[4]); end
    vec++; if (gd[8] !== 8'h08 || gl[8] !== 1'b1 || dcyc[0] !== 18) begin errs++; $display("FAIL rm_csum got %h/%b t=%0d exp 08/1 t=18", gd[8], gl[8], dcyc[0]); end
  endtask

  task automatic test_reg_change();
    for (int i = 0; i < 8; i++) regs[i] = 8'(i + 1);
    regs[0] = 8'h11;
    kick();
    collect(26, -1, 0, -1, -1, -1, 1);
    vec++; if (gd[0] !== 8'h11) begin errs++; $display("FAIL rc_byte0 got %h exp 11", gd[0]); end
    vec++; if (gd[8] !== 8'h18 || gl[8] !== 1'b1) begin errs++; $display("FAIL rc_csum got %h/%b exp 18/1", gd[8], gl[8]); end
  endtask

  initial begin
    start = 1'b0;
    out_ready = 1'b1;
    reset = 1'b1;
    for (int i = 0; i < 8; i++) regs[i] = 8'h00;
    @(negedge clk);
    test_reset();
    test_incrementing();
    test_all_a5();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_reg_change();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
